// File: rtl/amm_arb_ram.sv
// -----------------------------------------------------------------------------
// amm_arb_ram
//   Single-ported word memory with two Avalon-MM slave ports: a read port and a
//   byte-enabled write port. At most one access is made per cycle. When both
//   ports request in the same cycle, a round-robin pointer chooses the winner
//   and the loser gets waitrequest. Read data returns through a fixed-latency
//   pipeline qualified by readdatavalid.
//
// Ports
//   clk_i                   clock
//   arst_n_i                asynchronous active-low reset
//   amm_rd_address_i        read word address
//   amm_rd_read_i           read request
//   amm_rd_readdata_o       read data, held between valid pulses
//   amm_rd_readdatavalid_o  one-cycle qualifier, READ_LATENCY cycles after accept
//   amm_rd_waitrequest_o    read not accepted this cycle
//   amm_wr_address_i        write word address
//   amm_wr_write_i          write request
//   amm_wr_writedata_i      write data
//   amm_wr_byteenable_i     byte lane enables, bit k covers bits [8k+7:8k]
//   amm_wr_waitrequest_o    write not accepted this cycle
//
// DATA_WIDTH must be a multiple of 8. READ_LATENCY is legal from 1 to 4.
// -----------------------------------------------------------------------------
module amm_arb_ram #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 10,
  parameter int BYTE_CNT     = DATA_WIDTH / 8,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic [ADDR_WIDTH-1:0] amm_rd_address_i,
  input  logic                  amm_rd_read_i,
  output logic [DATA_WIDTH-1:0] amm_rd_readdata_o,
  output logic                  amm_rd_readdatavalid_o,
  output logic                  amm_rd_waitrequest_o,
  input  logic [ADDR_WIDTH-1:0] amm_wr_address_i,
  input  logic                  amm_wr_write_i,
  input  logic [DATA_WIDTH-1:0] amm_wr_writedata_i,
  input  logic [BYTE_CNT-1:0]   amm_wr_byteenable_i,
  output logic                  amm_wr_waitrequest_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Which port wins the next contended cycle.
  typedef enum logic {
    PRI_RD = 1'b0,
    PRI_WR = 1'b1
  } pri_e;

  logic [1:0]            rst_sync_q;
  logic                  ready;
  pri_e                  pri_q;
  pri_e                  pri_d;
  logic                  contend;
  logic                  rd_grant;
  logic                  wr_grant;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [READ_LATENCY-1:0] vld_q;
  logic [DATA_WIDTH-1:0] dat_q [READ_LATENCY];

  // Reset release is taken through two flops so that both ports keep
  // waitrequest high until the deassertion has settled in this clock domain.
  // NOTE: clocked state is assigned with <= so every flop samples the values
  // from before the edge; = here would chain the two stages into one.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign ready = rst_sync_q[1];

  // Arbitration. An idle port sees waitrequest low; under contention the port
  // named by the pointer wins and the pointer moves to the loser, so a stalled
  // port is never held off for more than one cycle.
  // NOTE: every output of this block gets a value before any condition, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    contend              = amm_rd_read_i & amm_wr_write_i;
    amm_rd_waitrequest_o = !ready | (contend & (pri_q == PRI_WR));
    amm_wr_waitrequest_o = !ready | (contend & (pri_q == PRI_RD));
    rd_grant             = amm_rd_read_i  & ~amm_rd_waitrequest_o;
    wr_grant             = amm_wr_write_i & ~amm_wr_waitrequest_o;
    pri_d                = pri_q;
    if (ready && contend) begin
      pri_d = (pri_q == PRI_RD) ? PRI_WR : PRI_RD;
    end
  end

  // Storage array with per-lane write enables.
  // NOTE: the array has no reset; contents survive a reset and clearing a RAM
  // would need a sequencer, not a reset branch.
  always_ff @(posedge clk_i) begin
    if (wr_grant) begin
      for (int k = 0; k < BYTE_CNT; k++) begin
        if (amm_wr_byteenable_i[k]) begin
          mem_q[amm_wr_address_i][8*k +: 8] <= amm_wr_writedata_i[8*k +: 8];
        end
      end
    end
  end

  // Read pipeline: stage 0 samples the array at the accept edge, each later
  // stage copies its predecessor only when that predecessor is valid. The last
  // stage is the output register, so readdata holds between valid pulses.
  // Reset clears the valid bits, discarding reads already in flight.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      pri_q <= PRI_RD;
      vld_q <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      pri_q    <= pri_d;
      vld_q[0] <= rd_grant;
      if (rd_grant) begin
        dat_q[0] <= mem_q[amm_rd_address_i];
      end
      for (int k = 1; k < READ_LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          dat_q[k] <= dat_q[k-1];
        end
      end
    end
  end

  assign amm_rd_readdatavalid_o = vld_q[READ_LATENCY-1];
  assign amm_rd_readdata_o      = dat_q[READ_LATENCY-1];

endmodule

// File: doc/amm_arb_ram.md
Name: amm_arb_ram

Overview:
- Single-ported word memory model/IP serving two Avalon-MM slave ports: a read port and a write port with byteenable.
- Sits directly downstream of the byte-increment engine: its read master fetches source words here, and its write master stores incremented words back here.
- One memory access per cycle; simultaneous read and write requests are resolved by a round-robin arbiter; read data returns over a fixed-latency pipeline with readdatavalid.

Parameters:
- DATA_WIDTH, 64, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10, word address width; memory depth is 2**ADDR_WIDTH words.
- BYTE_CNT, DATA_WIDTH/8, number of byteenable bits.
- READ_LATENCY, 2, cycles from accepted read to readdatavalid; legal range 1..4.

Ports:
- clk_i  in  1  clock.
- arst_n_i  in  1  asynchronous active-low reset.
- amm_rd_address_i  in  ADDR_WIDTH  read word address.
- amm_rd_read_i  in  1  read request.
- amm_rd_readdata_o  out  DATA_WIDTH  read data.
- amm_rd_readdatavalid_o  out  1  readdata qualifier.
- amm_rd_waitrequest_o  out  1  read request not accepted this cycle.
- amm_wr_address_i  in  ADDR_WIDTH  write word address.
- amm_wr_write_i  in  1  write request.
- amm_wr_writedata_i  in  DATA_WIDTH  write data.
- amm_wr_byteenable_i  in  BYTE_CNT  byte lane enables; bit k covers bits [8k+7:8k].
- amm_wr_waitrequest_o  out  1  write request not accepted this cycle.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Port names are clk_i and arst_n_i.
- Reset values:
  - readdatavalid_o = 0 and readdata_o = 0.
  - Read-pipeline valid bits cleared.
  - Arbiter priority pointer = READ.
  - Both waitrequest outputs = 1 while arst_n_i = 0.
  - Memory contents are not cleared; unwritten words read as X.
- Acceptance: a request is accepted on a rising edge where its request is 1 and its waitrequest is 0.
- Waitrequest is combinational from the requests and the priority pointer:
  - Only one port requesting: that port's waitrequest = 0.
  - Both requesting: the port named by the pointer wins (waitrequest = 0); the other gets waitrequest = 1.
  - No request on a port: that port's waitrequest = 0.
- Priority pointer update: only on a cycle where both ports request. It then flips to the losing port, so a stalled port wins the next contended cycle. Starvation is bounded to 1 cycle.
- Write:
  - An accepted write updates only lanes with byteenable = 1 at the accept edge.
  - byteenable = 0 is accepted but changes nothing.
- Read:
  - An accepted read samples the memory word at the accept edge and enters a READ_LATENCY-deep valid/data shift pipeline.
  - readdatavalid_o = 1 exactly READ_LATENCY cycles after acceptance, for 1 cycle.
  - Fully pipelined: back-to-back reads give back-to-back valids in request order.
  - readdata_o holds its last value when readdatavalid_o = 0.
- Hazard: a read and write to the same address cannot be accepted in the same cycle (single port). A read accepted the cycle after a write to the same address returns the new data.
- Addresses wrap naturally at 2**ADDR_WIDTH; no out-of-range case exists.
- Requests must be held stable while waitrequest = 1 (master obligation). The block does not latch a stalled request.
- Reset mid-operation: in-flight reads are discarded; no readdatavalid after reset deasserts for reads accepted before reset. Memory contents written before reset are retained.
- Deasserting reset is synchronised internally (2-flop) before waitrequest drops.

Test Plan:
- Write 0x0807060504030201 to 0x010 with byteenable 0xFF, then read 0x010 -> readdatavalid exactly 2 cycles after accept, readdata 0x0807060504030201.
- Write 0xFFFFFFFFFFFFFFFF to 0x010 with byteenable 0x0F, then read -> 0x08070605FFFFFFFF.
- Hold read and write to different addresses asserted for 4 cycles, starting from reset -> grants alternate R, W, R, W. The loser sees waitrequest = 1 each cycle, and each port is stalled at most 1 cycle.
- Issue 3 back-to-back reads of 0x010, 0x011, 0x012 (prefilled 0xA0, 0xA1, 0xA2) -> 3 consecutive readdatavalid pulses with data in order.
- Write to 0x3FF, then read at address 0x3FF -> correct data; writing to address 0x000 does not alias 0x3FF.
- Accept 2 reads, then pulse arst_n_i low for 1 cycle before data returns -> no readdatavalid, waitrequest = 1 during reset, and memory at 0x010 still returns its earlier value afterward.
